ofdm_rx_ctrl: RTL
=================

Name: ofdm_rx_ctrl

Overview:
- Receive-sequencing controller for the 802.11a RX chain.
- Arms the short-training-sequence packet detector, then hands over in turn to LTS symbol sync, SIGNAL-field decode and DATA-symbol decode.
- Validates the SIGNAL field, counts DATA symbols from RATE/LENGTH, and enforces per-stage timeouts measured in valid samples.
- Reports completion or error to the MAC interface.

Parameters:
- TIMER_W, 12, width of timeout counter.
- LTS_TIMEOUT, 320, valid samples allowed from STS detect to lts_sync_flag.
- SIG_TIMEOUT, 240, valid samples allowed from LTS sync to signal_valid.
- SYM_TIMEOUT, 160, valid samples allowed between successive data_symbol_done pulses (first measured from DATA entry).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  receiver enable.
- sample_in_valid  in  1  sample strobe; timers advance only on it.
- sts_detect_flag  in  1  pulse from packet detector.
- lts_sync_flag  in  1  pulse from LTS symbol sync.
- signal_valid  in  1  pulse: SIGNAL field decoded.
- signal_parity_ok  in  1  SIGNAL parity check; qualified by signal_valid.
- signal_rate  in  4  RATE bits R1..R4; qualified by signal_valid.
- signal_length  in  12  LENGTH in bytes; qualified by signal_valid.
- data_symbol_done  in  1  pulse per decoded DATA symbol.
- rx_abort  in  1  external abort request.
- detect_enable  out  1  high in SEARCH.
- sync_enable  out  1  high in LTS_SYNC.
- signal_decode_enable  out  1  high in SIGNAL.
- data_decode_enable  out  1  high in DATA.
- rx_busy  out  1  high in LTS_SYNC, SIGNAL, DATA.
- rx_done  out  1  one-cycle completion pulse.
- rx_error  out  1  one-cycle error pulse.
- error_code  out  3  last error cause, held until the next SIGNAL state is entered.
- rx_rate  out  4  latched RATE.
- rx_length  out  12  latched LENGTH.
- rx_ndbps  out  8  latched data bits per symbol.
- sym_count  out  11  DATA symbols received in the current packet.

Behaviour:
- Reset: all outputs 0. State returns to IDLE.
- States: IDLE, SEARCH, LTS_SYNC, SIGNAL, DATA, DONE, ERR. All outputs are registered; each enable asserts in the cycle after its state is entered.
- Timer:
  - Clears on every state entry.
  - Increments on sample_in_valid in LTS_SYNC, SIGNAL and DATA.
  - Clears on each data_symbol_done.
  - A timeout is reached when timer == limit−1 with sample_in_valid high.
- IDLE: go to SEARCH when enable=1.
- SEARCH: sts_detect_flag moves to LTS_SYNC.
- LTS_SYNC:
  - lts_sync_flag moves to SIGNAL.
  - LTS_TIMEOUT moves to ERR, code 1.
- SIGNAL:
  - On entry, error_code clears to 0.
  - On signal_valid, latch rate and length, then check in priority order:
    - parity fail: code 2.
    - RATE not in {1101,1111,0101,0111,1001,1011,0001,0011}: code 3.
    - length==0: code 4.
    - otherwise go to DATA.
  - SIG_TIMEOUT moves to ERR, code 5.
- N_DBPS by RATE code: 1101=24, 1111=36, 0101=48, 0111=72, 1001=96, 1011=144, 0001=192, 0011=216.
- DATA:
  - On entry: remaining_bits = 22 + 8*length (16-bit unsigned, max 32782); sym_count = 0.
  - On data_symbol_done: sym_count+1.
    - If remaining_bits <= N_DBPS, go to DONE.
    - Else remaining_bits -= N_DBPS.
  - SYM_TIMEOUT moves to ERR, code 5.
- DONE: rx_done=1 for one cycle. Next state is SEARCH if enable, else IDLE.
- ERR: rx_error=1 for one cycle. Next state is SEARCH if enable, else IDLE.
- rx_abort:
  - In LTS_SYNC, SIGNAL or DATA: go to ERR, code 6.
  - Ignored in IDLE and SEARCH.
- enable=0 in any state except DONE/ERR: go to IDLE next cycle. No rx_done or rx_error pulse; error_code is unchanged.
- Priority per cycle: enable=0, then rx_abort, then stage event (flag/valid/done), then timeout. An event and a timeout in the same cycle resolve to the event.
- sym_count, rx_rate, rx_length and rx_ndbps hold their values after DONE/ERR until the next packet overwrites them.
- Async reset mid-packet: immediate return to the reset values.

Test Plan:
- Good packet, RATE=1101, length=100: remaining=822. After STS, LTS, SIGNAL, 35 data_symbol_done pulses -> rx_done pulse, sym_count=35, rx_ndbps=24, back in SEARCH.
- RATE=0011, length=4095: remaining=32782. Exactly 152 symbols -> rx_done. A 153rd pulse arriving after DONE is ignored.
- signal_valid with parity_ok=0 -> rx_error pulse, error_code=2. Repeat with RATE=0000 -> code 3; with length=0 -> code 4.
- After STS, no lts_sync_flag for 320 valid samples -> rx_error on the 320th sample, code 1. A flag at sample 319 (or coincident with the 320th) -> SIGNAL instead.
- rx_abort in DATA -> code 6. enable dropped in SIGNAL -> IDLE with no pulses and all enables 0.
- rst_n asserted in DATA -> all outputs 0 immediately. After release with enable=1 -> SEARCH and detect_enable=1 within 2 cycles.

Source files
------------

// File: rtl/ofdm_rx_ctrl.sv
// 802.11a receive-sequencing controller: STS detect -> LTS sync -> SIGNAL -> DATA,
// with per-stage sample-count timeouts and SIGNAL-field validation.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | receiver disabled
// SEARCH   | packet detector armed, waiting for STS
// LTS_SYNC | waiting for LTS symbol sync
// SIGNAL   | waiting for SIGNAL field decode
// DATA     | counting DATA symbols against RATE/LENGTH budget
// DONE     | packet complete, one-cycle rx_done
// ERR      | packet aborted, one-cycle rx_error
module ofdm_rx_ctrl #(
  parameter int TIMER_W     = 12,
  parameter int LTS_TIMEOUT = 320,
  parameter int SIG_TIMEOUT = 240,
  parameter int SYM_TIMEOUT = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sample_in_valid,
  input  logic        sts_detect_flag,
  input  logic        lts_sync_flag,
  input  logic        signal_valid,
  input  logic        signal_parity_ok,
  input  logic [3:0]  signal_rate,
  input  logic [11:0] signal_length,
  input  logic        data_symbol_done,
  input  logic        rx_abort,
  output logic        detect_enable,
  output logic        sync_enable,
  output logic        signal_decode_enable,
  output logic        data_decode_enable,
  output logic        rx_busy,
  output logic        rx_done,
  output logic        rx_error,
  output logic [2:0]  error_code,
  output logic [3:0]  rx_rate,
  output logic [11:0] rx_length,
  output logic [7:0]  rx_ndbps,
  output logic [10:0] sym_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_LTS_SYNC, S_SIGNAL, S_DATA, S_DONE, S_ERR
  } state_t;

  state_t             state, state_nx;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] limit;
  logic [15:0]        remaining;
  logic [7:0]         ndbps_lut;
  logic               timed, timeout, err_set;
  logic [2:0]         err_nx;

  always_comb begin
    case (signal_rate)
      4'b1101: ndbps_lut = 8'd24;
      4'b1111: ndbps_lut = 8'd36;
      4'b0101: ndbps_lut = 8'd48;
      4'b0111: ndbps_lut = 8'd72;
      4'b1001: ndbps_lut = 8'd96;
      4'b1011: ndbps_lut = 8'd144;
      4'b0001: ndbps_lut = 8'd192;
      4'b0011: ndbps_lut = 8'd216;
      default: ndbps_lut = 8'd0;
    endcase
  end

  always_comb begin
    limit = TIMER_W'(SYM_TIMEOUT - 1);
    timed = 1'b0;
    case (state)
      S_LTS_SYNC: begin limit = TIMER_W'(LTS_TIMEOUT - 1); timed = 1'b1; end
      S_SIGNAL:   begin limit = TIMER_W'(SIG_TIMEOUT - 1); timed = 1'b1; end
      S_DATA:     timed = 1'b1;
      default:    timed = 1'b0;
    endcase
    timeout = timed && sample_in_valid && (timer == limit);
  end

  // Priority: enable low, abort, stage event, timeout.
  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    err_nx   = 3'd0;
    case (state)
      S_IDLE:   if (enable) state_nx = S_SEARCH;
      S_SEARCH: begin
        if (!enable)              state_nx = S_IDLE;
        else if (sts_detect_flag) state_nx = S_LTS_SYNC;
      end
      S_LTS_SYNC: begin
        if (!enable)            state_nx = S_IDLE;
        else if (rx_abort)      begin err_set = 1'b1; err_nx = 3'd6; end
        else if (lts_sync_flag) state_nx = S_SIGNAL;
        else if (timeout)       begin err_set = 1'b1; err_nx = 3'd1; end
      end
      S_SIGNAL: begin
        if (!enable)        state_nx = S_IDLE;
        else if (rx_abort)  begin err_set = 1'b1; err_nx = 3'd6; end
        else if (signal_valid) begin
          if (!signal_parity_ok)       begin err_set = 1'b1; err_nx = 3'd2; end
          else if (ndbps_lut == 8'd0)  begin err_set = 1'b1; err_nx = 3'd3; end
          else if (signal_length == 12'd0) begin err_set = 1'b1; err_nx = 3'd4; end
          else                         state_nx = S_DATA;
        end
        else if (timeout)   begin err_set = 1'b1; err_nx = 3'd5; end
      end
      S_DATA: begin
        if (!enable)       state_nx = S_IDLE;
        else if (rx_abort) begin err_set = 1'b1; err_nx = 3'd6; end
        else if (data_symbol_done) begin
          if (remaining <= {8'd0, rx_ndbps}) state_nx = S_DONE;
        end
        else if (timeout)  begin err_set = 1'b1; err_nx = 3'd5; end
      end
      S_DONE, S_ERR: state_nx = enable ? S_SEARCH : S_IDLE;
      default:       state_nx = S_IDLE;
    endcase
    if (err_set) state_nx = S_ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      timer                <= '0;
      remaining            <= '0;
      detect_enable        <= 1'b0;
      sync_enable          <= 1'b0;
      signal_decode_enable <= 1'b0;
      data_decode_enable   <= 1'b0;
      rx_busy              <= 1'b0;
      rx_done              <= 1'b0;
      rx_error             <= 1'b0;
      error_code           <= '0;
      rx_rate              <= '0;
      rx_length            <= '0;
      rx_ndbps             <= '0;
      sym_count            <= '0;
    end else begin
      state <= state_nx;

      if (state_nx != state)                          timer <= '0;
      else if (state == S_DATA && data_symbol_done)   timer <= '0;
      else if (timed && sample_in_valid)             timer <= timer + TIMER_W'(1);

      if (state == S_SIGNAL && signal_valid) begin
        rx_rate   <= signal_rate;
        rx_length <= signal_length;
        rx_ndbps  <= ndbps_lut;
      end

      // remaining_bits = SERVICE(16) + tail(6) + 8*LENGTH
      if (state_nx == S_DATA && state != S_DATA) begin
        remaining <= 16'd22 + {1'b0, signal_length, 3'b000};
        sym_count <= '0;
      end else if (state == S_DATA && data_symbol_done &&
                   (state_nx == S_DATA || state_nx == S_DONE)) begin
        sym_count <= sym_count + 11'd1;
        if (state_nx == S_DATA) remaining <= remaining - {8'd0, rx_ndbps};
      end

      if (state_nx == S_SIGNAL && state != S_SIGNAL) error_code <= '0;
      else if (err_set)                              error_code <= err_nx;

      detect_enable        <= (state == S_SEARCH);
      sync_enable          <= (state == S_LTS_SYNC);
      signal_decode_enable <= (state == S_SIGNAL);
      data_decode_enable   <= (state == S_DATA);
      rx_busy              <= (state == S_LTS_SYNC) || (state == S_SIGNAL) || (state == S_DATA);
      rx_done              <= (state == S_DONE);
      rx_error             <= (state == S_ERR);
    end
  end

endmodule
